// File: rtl/ant_update_scheduler_pkg.sv
// Shared constants and state encoding for the ant-update scheduler, used by the
// initializer, the update datapath and the debug HEX display.
package ant_update_scheduler_pkg;

    localparam int ANT_num      = 4;
    localparam int ANT_num_bits = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3
    } sched_state_e;

    // Width that can hold 0..max_val, never less than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ant_update_scheduler_sat_counter.sv
// Saturating up-counter with increment enable and asynchronous clear; holds at
// all-ones once reached.
module sat_counter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [N-1:0] cnt
);

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + N'(1);
        end
    end

    // NOTE: state flops use non-blocking assignments and an asynchronous clear in the sensitivity list.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ant_update_scheduler.sv
// Game-loop sequencer: on each tick, issues one start per ant and waits for its
// done (or a timeout) before moving on, then pulses frame_done.
module ant_update_scheduler
    import ant_update_scheduler_pkg::*;
#(
    parameter int ANT_NUM     = ANT_num,
    parameter int ANT_ID_BITS = ANT_num_bits,
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_BITS    = 8
) (
    input  logic                   Clk,
    input  logic                   RESET_SIM,
    input  logic                   SETUP_MODE,
    input  logic                   tick,
    output logic                   upd_start,
    output logic [ANT_ID_BITS-1:0] upd_ant_id,
    input  logic                   upd_done,
    output logic                   busy,
    output logic                   frame_done,
    output logic [CNT_BITS-1:0]    overrun_cnt,
    output logic [CNT_BITS-1:0]    timeout_cnt,
    output logic [2:0]             state_o
);

    localparam int WAIT_BITS = cnt_width(TIMEOUT_CYC);

    sched_state_e           state_q, state_d;
    logic [ANT_ID_BITS-1:0] ant_id_q, ant_id_d;
    logic [WAIT_BITS-1:0]   wait_q, wait_d;

    logic last_ant;
    logic wait_expired;
    logic timeout_inc;
    logic overrun_inc;

    assign last_ant     = (ant_id_q == ANT_ID_BITS'(ANT_NUM - 1));
    // wait_q counts completed WAIT cycles, so the TIMEOUT_CYC-th cycle sees TIMEOUT_CYC-1.
    assign wait_expired = (wait_q == WAIT_BITS'(TIMEOUT_CYC - 1));

    always_ff @(posedge Clk or posedge RESET_SIM) begin
        if (RESET_SIM) begin
            state_q  <= ST_IDLE;
            ant_id_q <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            ant_id_q <= ant_id_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ant_id_d    = ant_id_q;
        wait_d      = wait_q;
        timeout_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ant_id_d = '0;
                if (tick && !SETUP_MODE) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wait_d = wait_q + WAIT_BITS'(1);
                if (upd_done || wait_expired) begin
                    // A done in the expiry cycle still counts as a completion.
                    timeout_inc = !upd_done;
                    if (last_ant) begin
                        state_d = ST_DONE;
                    end else begin
                        ant_id_d = ant_id_q + ANT_ID_BITS'(1);
                        state_d  = ST_ISSUE;
                    end
                end
            end
            ST_DONE: begin
                ant_id_d = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                ant_id_d = '0;
                state_d  = ST_IDLE;
            end
        endcase

        // The initializer reclaiming the datapath aborts the frame silently.
        if (SETUP_MODE && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            ant_id_d    = '0;
            timeout_inc = 1'b0;
        end
    end

    always_comb begin
        upd_start   = (state_q == ST_ISSUE);
        frame_done  = (state_q == ST_DONE);
        busy        = (state_q != ST_IDLE);
        upd_ant_id  = ant_id_q;
        state_o     = state_q;
        overrun_inc = tick && (state_q != ST_IDLE);
    end

    sat_counter #(.N(CNT_BITS)) u_overrun_cnt (
        .clk (Clk),
        .rst (RESET_SIM),
        .inc (overrun_inc),
        .cnt (overrun_cnt)
    );

    sat_counter #(.N(CNT_BITS)) u_timeout_cnt (
        .clk (Clk),
        .rst (RESET_SIM),
        .inc (timeout_inc),
        .cnt (timeout_cnt)
    );

endmodule

// File: tb/tb_ant_update_scheduler.sv
// Directed bench for ant_update_scheduler: 4 ants, 5-cycle timeout, 3-bit counters.
module tb_ant_update_scheduler;

    logic       Clk = 1'b0;
    logic       RESET_SIM;
    logic       SETUP_MODE;
    logic       tick;
    logic       upd_start;
    logic [1:0] upd_ant_id;
    logic       upd_done;
    logic       busy;
    logic       frame_done;
    logic [2:0] overrun_cnt;
    logic [2:0] timeout_cnt;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int hold  = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_ISSUE = 3'd1, S_WAIT = 3'd2, S_DONE = 3'd3;

    ant_update_scheduler #(
        .ANT_NUM     (4),
        .ANT_ID_BITS (2),
        .TIMEOUT_CYC (5),
        .CNT_BITS    (3)
    ) u_dut (
        .Clk         (Clk),
        .RESET_SIM   (RESET_SIM),
        .SETUP_MODE  (SETUP_MODE),
        .tick        (tick),
        .upd_start   (upd_start),
        .upd_ant_id  (upd_ant_id),
        .upd_done    (upd_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun_cnt (overrun_cnt),
        .timeout_cnt (timeout_cnt),
        .state_o     (state_o)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Step one clock; cycle index advances and tick stays high for the first `hold` cycles.
    task automatic adv();
        @(posedge Clk);
        #1;
        cyc++;
        tick = (cyc < hold);
    endtask

    initial begin
        RESET_SIM  = 1'b1;
        SETUP_MODE = 1'b0;
        tick       = 1'b0;
        upd_done   = 1'b0;
        #3;
        check("rst_state", state_o, S_IDLE);
        check("rst_busy", busy, 1'b0);
        check("rst_start", upd_start, 1'b0);
        check("rst_id", upd_ant_id, 2'd0);
        check("rst_ovr", overrun_cnt, 3'd0);
        check("rst_tmo", timeout_cnt, 3'd0);
        #9;
        RESET_SIM = 1'b0;
        @(posedge Clk);
        #1;

        // Frame with done 3 cycles after each start: starts at 1,5,9,13, frame_done at 17.
        cyc = 0; hold = 1; tick = 1'b1;
        adv();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f1_start_c%0d", cyc), upd_start, 1'b1);
            check($sformatf("f1_id_c%0d", cyc), upd_ant_id, i);
            adv();
            check($sformatf("f1_wait_c%0d", cyc), state_o, S_WAIT);
            check($sformatf("f1_nostart_c%0d", cyc), upd_start, 1'b0);
            adv();
            adv();
            upd_done = 1'b1;
            adv();
            upd_done = 1'b0;
        end
        check("f1_cycle", cyc, 17);
        check("f1_frame_done", frame_done, 1'b1);
        check("f1_done_state", state_o, S_DONE);
        adv();
        check("f1_busy_low", busy, 1'b0);
        check("f1_fd_low", frame_done, 1'b0);
        check("f1_ovr", overrun_cnt, 3'd0);

        // Tick held over cycles 0..4: one frame, four overruns.
        cyc = 0; hold = 5; tick = 1'b1;
        adv();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f2_id_c%0d", cyc), upd_ant_id, i);
            adv();
            adv();
            adv();
            upd_done = 1'b1;
            adv();
            upd_done = 1'b0;
        end
        check("f2_frame_done", frame_done, 1'b1);
        check("f2_ovr", overrun_cnt, 3'd4);
        adv();
        check("f2_idle", state_o, S_IDLE);

        // No done: every ant times out after 5 WAIT cycles; done in ISSUE is ignored.
        cyc = 0; hold = 1; tick = 1'b1;
        adv();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("f3_start_c%0d", cyc), upd_start, 1'b1);
            check($sformatf("f3_id_c%0d", cyc), upd_ant_id, i);
            upd_done = (i == 0);
            adv();
            upd_done = 1'b0;
            for (int w = 0; w < 5; w++) begin
                check($sformatf("f3_wait_c%0d", cyc), state_o, S_WAIT);
                adv();
            end
            check($sformatf("f3_tmo_c%0d", cyc), timeout_cnt, i + 1);
        end
        check("f3_cycle", cyc, 25);
        check("f3_frame_done", frame_done, 1'b1);
        adv();
        check("f3_idle", busy, 1'b0);

        // Done coincides with timeout on ant 0; then abort in WAIT of ant 2.
        cyc = 0; hold = 1; tick = 1'b1;
        adv();
        for (int k = 0; k < 5; k++) adv();
        check("f4_still_wait", state_o, S_WAIT);
        upd_done = 1'b1;
        adv();
        upd_done = 1'b0;
        check("f4_issue_id1", upd_ant_id, 2'd1);
        check("f4_start", upd_start, 1'b1);
        check("f4_tmo_kept", timeout_cnt, 3'd4);
        adv();
        upd_done = 1'b1;
        adv();
        upd_done = 1'b0;
        check("f4_issue_id2", upd_ant_id, 2'd2);
        adv();
        SETUP_MODE = 1'b1;
        adv();
        check("f5_abort_state", state_o, S_IDLE);
        check("f5_abort_id", upd_ant_id, 2'd0);
        check("f5_abort_fd", frame_done, 1'b0);
        check("f5_abort_busy", busy, 1'b0);
        tick = 1'b1;
        adv();
        check("f5_setup_tick_state", state_o, S_IDLE);
        check("f5_setup_tick_ovr", overrun_cnt, 3'd4);
        SETUP_MODE = 1'b0;
        tick = 1'b0;
        adv();
        check("f5_no_fd", frame_done, 1'b0);

        // Restart from ant 0 with tick held so overrun saturates, then async reset mid-WAIT.
        cyc = 0; hold = 6; tick = 1'b1;
        adv();
        check("f6_restart_start", upd_start, 1'b1);
        check("f6_restart_id", upd_ant_id, 2'd0);
        for (int k = 0; k < 5; k++) adv();
        check("f6_ovr_sat", overrun_cnt, 3'd7);
        adv();
        check("f6_issue_id1", upd_ant_id, 2'd1);
        check("f6_tmo", timeout_cnt, 3'd5);
        adv();
        check("f6_wait", state_o, S_WAIT);
        #2;
        RESET_SIM = 1'b1;
        #1;
        check("r_state", state_o, S_IDLE);
        check("r_id", upd_ant_id, 2'd0);
        check("r_busy", busy, 1'b0);
        check("r_start", upd_start, 1'b0);
        check("r_fd", frame_done, 1'b0);
        check("r_ovr", overrun_cnt, 3'd0);
        check("r_tmo", timeout_cnt, 3'd0);
        #3;
        RESET_SIM = 1'b0;
        @(posedge Clk);
        #1;
        check("r_after_idle", state_o, S_IDLE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ant_update_scheduler.md
Name: ant_update_scheduler

Overview:
- Game-loop sequencer for the shared ant-update datapath. It is idle while SETUP_MODE is high.
- On each game tick it walks ant_id 0..ANT_num-1 and issues one start pulse per ant. It waits for that ant's done handshake before moving to the next ant.
- It pulses frame_done when all ants have been processed.
- It sits between the initializer (SETUP_MODE), the tick generator, and the ant-update/location-write datapath.

Parameters:
- ANT_NUM, default ANT_num (params.sv): number of ants updated per tick.
- ANT_ID_BITS, default ANT_num_bits: width of the ant index.
- TIMEOUT_CYC, default 255: maximum WAIT cycles per ant before that ant is skipped.
- CNT_BITS, default 8: width of the saturating diagnostic counters.

Ports:
- Clk  in  1  system clock.
- RESET_SIM  in  1  asynchronous, active-high reset.
- SETUP_MODE  in  1  high while the initializer owns the datapath; forces IDLE.
- tick  in  1  one-cycle game-loop pulse.
- upd_start  out  1  one-cycle start to the ant-update datapath.
- upd_ant_id  out  ANT_ID_BITS  ant being updated; stable from ISSUE through WAIT.
- upd_done  in  1  datapath completion, one cycle.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse after the last ant completes.
- overrun_cnt  out  CNT_BITS  ticks dropped because the scheduler was busy; saturating.
- timeout_cnt  out  CNT_BITS  ants skipped on timeout; saturating.
- state_o  out  3  debug copy of the state.

Behaviour:
- Reset (async, RESET_SIM=1): state=IDLE; upd_ant_id=0; wait counter=0; overrun_cnt=0; timeout_cnt=0. All outputs are 0 while reset is held.
- States: IDLE, ISSUE, WAIT, DONE. Encodings are 0..3 on state_o.
- IDLE:
  - upd_ant_id=0.
  - If tick=1 and SETUP_MODE=0, go to ISSUE next cycle.
  - A tick while SETUP_MODE=1 is ignored and not counted.
- ISSUE:
  - upd_start=1 for exactly this cycle.
  - Clear the wait counter and go to WAIT.
- WAIT:
  - The wait counter increments each cycle.
  - If upd_done=1, the current ant is complete:
    - if upd_ant_id==ANT_NUM-1, go to DONE;
    - otherwise upd_ant_id+=1 and go to ISSUE.
  - If upd_done=0 and the wait counter reaches TIMEOUT_CYC:
    - timeout_cnt+=1, saturating;
    - advance exactly as on done.
  - If done and timeout occur in the same cycle, done wins and timeout_cnt is unchanged.
- upd_done outside WAIT (including in the ISSUE cycle) is ignored.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Latency: a tick sampled at edge 0 gives ISSUE in cycle 1. Each ant costs 1 ISSUE cycle plus the WAIT length. frame_done follows the last done by one cycle.
- Overrun: tick=1 in any non-IDLE state gives overrun_cnt+=1 (saturates at all-ones); the tick is otherwise dropped and not queued. A tick in the DONE cycle counts as overrun.
- SETUP_MODE rising in any non-IDLE state:
  - synchronous abort to IDLE on the next edge;
  - upd_ant_id=0;
  - no frame_done is issued;
  - counters are kept.
- upd_ant_id does not wrap inside a frame; the final ant exits to DONE.
- Counters clear only on RESET_SIM.

Decomposition:
- ANT_num, ANT_num_bits and the scheduler state enum (logic [2:0]) go in params.sv so the initializer, datapath and debug HEX display share them.
- Sub-module sat_counter #(N): increment-enable, async clear, saturate at all-ones. It is instantiated twice, for overrun_cnt and timeout_cnt.
- The wait counter stays inline.

Test Plan:
- ANT_NUM=4, SETUP_MODE=0, tick at cycle 0, datapath asserts done 3 cycles after each start:
  - upd_start at cycles 1, 5, 9, 13 with ids 0, 1, 2, 3;
  - frame_done at cycle 17;
  - busy low from cycle 18.
- tick held high cycles 0..4 with the same datapath: one frame runs and overrun_cnt=4.
- Datapath never asserts done, TIMEOUT_CYC=5, ANT_NUM=2:
  - each ant is skipped after 5 WAIT cycles;
  - timeout_cnt=2 and frame_done still pulses.
- done and timeout in the same cycle: ant advances and timeout_cnt is unchanged.
- SETUP_MODE asserted in the WAIT of ant 2: IDLE next cycle, upd_ant_id=0, no frame_done; a later tick restarts from ant 0.
- RESET_SIM pulsed mid-WAIT, asynchronously between edges: all outputs 0 immediately, and counters clear.
